sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive data-port wins allowed while fetch waits.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 if_req / if_addr  in  1 / AW  fetch request, held until if_gnt; address.
REQ-007 if_gnt / if_rvalid / if_rdata  out  1 / 1 / DW  fetch accept pulse; response pulse; response data.
REQ-008 dm_req / dm_we / dm_wstrb / dm_addr / dm_wdata  in  1 / 1 / 4 / AW / DW  data request, held until dm_gnt; write flag; byte strobes; address; write data.
REQ-009 dm_gnt / dm_rvalid / dm_rdata  out  1 / 1 / DW  data accept pulse; response pulse; response data.
REQ-010 mem_req / mem_we / mem_wstrb / mem_addr / mem_wdata  out  1 / 1 / 4 / AW / DW  shared memory port request and payload.
REQ-011 mem_gnt / mem_rvalid / mem_rdata  in  1 / 1 / DW  memory accept; response (reads and writes); read data.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, REQ, RESP; exactly one transaction outstanding at any time.
REQ-014 IDLE: if any request is present, latch winner (owner) and its addr/we/wstrb/wdata into registers, then go to REQ; otherwise stay in IDLE.
REQ-015 Winner: dm if dm_req and (no if_req or starve_cnt < STARVE_LIMIT); else if.
REQ-016 Fetch requests carry mem_we=0 and mem_wstrb=0.
REQ-017 starve_cnt increments when dm wins while if_req=1, clears to 0 when if wins, and saturates at STARVE_LIMIT.
REQ-018 REQ: mem_req=1 and all mem_* payload driven only from latched registers; hold stable until mem_gnt.
REQ-019 REQ with mem_gnt=1: pulse owner's gnt (if_gnt or dm_gnt) for exactly that cycle; go to RESP.
REQ-020 RESP: mem_req=0; on mem_rvalid=1 pulse owner's rvalid for that cycle; go to IDLE.
REQ-021 if_rdata and dm_rdata both equal mem_rdata combinationally; only the owner's rvalid asserts.
REQ-022 mem_rvalid outside RESP is ignored; neither rvalid asserts.
REQ-023 Latency: request first seen in IDLE at cycle N gives mem_req at N+1; with zero-wait memory, gnt at N+1 and earliest rvalid at N+2; next arbitration at N+3.
REQ-024 Requests arriving in REQ or RESP are not sampled until the next IDLE cycle.
REQ-025 A requester dropping req after being latched does not cancel the transaction.
REQ-026 No gnt or rvalid to a non-owner; at most one of if_gnt/dm_gnt is high per cycle.

Reset
REQ-027 rst: state IDLE, starve_cnt 0, owner and latched payload 0.
REQ-028 During and after reset: all out ports 0.
REQ-029 rst mid-transaction drops mem_req and discards any pending response; no rvalid pulses for it.

Verification
REQ-030 Only if_req, if_addr=0x100, mem_gnt tied 1, rvalid one cycle after gnt with rdata=0x13: mem_req and if_gnt at cycle 1; if_rvalid with if_rdata=0x13 at cycle 2; busy low at cycle 3.
REQ-031 if_req and dm_req held together continuously, STARVE_LIMIT=4: grant order dm,dm,dm,dm,if, repeating.
REQ-032 dm write, addr=0x2000, wdata=0xDEADBEEF, wstrb=0xF, mem_gnt delayed 3 cycles: payload stable for the 3 wait cycles; dm_gnt only on the gnt cycle; if_gnt stays 0.
REQ-033 rst asserted in RESP, then mem_rvalid=1 one cycle later: no if_rvalid or dm_rvalid; busy=0; next request is arbitrated normally.
REQ-034 Stray mem_rvalid while in IDLE: no rvalid output, and state and starve_cnt are unchanged.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Signal bundle between the fetch port, the data port, the arbiter and the shared SRAM port.
interface sram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [3:0]    dm_wstrb;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Fetch/data arbiter onto one SRAM port with a single transaction in flight; the data
// port wins ties until the fetch port has lost STARVE_LIMIT arbitrations in a row.
module sram_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus,
  output logic          busy_o
);
  localparam int            CW    = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2} state_e;

  state_e        state_q;
  logic          owner_q;  // 1'b1: data port owns the transaction
  logic          mem_req_q;
  logic          we_q;
  logic [3:0]    wstrb_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;
  logic          dm_win_d;

  // Winner selection and starvation count for an arbitration taken this cycle
  always_comb begin
    dm_win_d = 1'b0;
    starve_d = starve_q;
    if (bus.dm_req && (!bus.if_req || (starve_q < LIMIT))) dm_win_d = 1'b1;
    else dm_win_d = 1'b0;
    // dm only beats a waiting fetch below LIMIT, so the increment saturates by construction
    if (dm_win_d && bus.if_req) starve_d = starve_q + CW'(1);
    else if (!dm_win_d && bus.if_req) starve_d = '0;
    else starve_d = starve_q;
  end

  // Transaction FSM: latch winner in IDLE, present it until accepted, await response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      wstrb_q   <= 4'h0;
      addr_q    <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.if_req || bus.dm_req) begin
            owner_q   <= dm_win_d;
            addr_q    <= dm_win_d ? bus.dm_addr : bus.if_addr;
            we_q      <= dm_win_d & bus.dm_we;
            wstrb_q   <= dm_win_d ? bus.dm_wstrb : 4'h0;
            wdata_q   <= dm_win_d ? bus.dm_wdata : '0;
            starve_q  <= starve_d;
            mem_req_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.mem_rvalid) state_q <= ST_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Every output is forced low while reset is held, whatever state reset interrupted
  assign busy_o        = !rst && (state_q != ST_IDLE);
  assign bus.mem_req   = !rst && mem_req_q;
  assign bus.mem_we    = !rst && we_q;
  assign bus.mem_wstrb = rst ? 4'h0 : wstrb_q;
  assign bus.mem_addr  = rst ? '0 : addr_q;
  assign bus.mem_wdata = rst ? '0 : wdata_q;

  assign bus.if_gnt    = !rst && (state_q == ST_REQ) && bus.mem_gnt && !owner_q;
  assign bus.dm_gnt    = !rst && (state_q == ST_REQ) && bus.mem_gnt && owner_q;
  assign bus.if_rvalid = !rst && (state_q == ST_RESP) && bus.mem_rvalid && !owner_q;
  assign bus.dm_rvalid = !rst && (state_q == ST_RESP) && bus.mem_rvalid && owner_q;
  assign bus.if_rdata  = rst ? '0 : bus.mem_rdata;
  assign bus.dm_rdata  = rst ? '0 : bus.mem_rdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: cycle vector table, directed multi-cycle sequences and a
// randomized run against a transaction-queue reference model.
module tb_sram_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  sram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy_o(busy)
  );

  typedef struct {
    logic        rst, ifr, dmr, dwe, mg, mrv;
    logic [31:0] ia, da, dwd, mrd;
    logic [3:0]  dws;
  } in_t;

  typedef struct {
    in_t         i;
    logic [5:0]  e;   // {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, busy}
    logic [31:0] ma;
  } vec_t;

  typedef struct {
    logic        owner;  // 1 = data port
    logic [31:0] addr, wdata;
    logic        we;
    logic [3:0]  wstrb;
    logic        granted;
  } tx_t;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vt[$];
  in_t  v;
  tx_t  txq[$];
  int   m_starve;
  logic seen_ig, seen_dg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t x);
    rst            = x.rst;
    bus.if_req     = x.ifr;
    bus.if_addr    = x.ia;
    bus.dm_req     = x.dmr;
    bus.dm_we      = x.dwe;
    bus.dm_addr    = x.da;
    bus.dm_wdata   = x.dwd;
    bus.dm_wstrb   = x.dws;
    bus.mem_gnt    = x.mg;
    bus.mem_rvalid = x.mrv;
    bus.mem_rdata  = x.mrd;
  endtask

  // ctl = {rst, if_req, dm_req, mem_gnt, mem_rvalid}
  function automatic vec_t row(input logic [4:0] ctl, input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] mrd, input logic [5:0] e, input logic [31:0] ma);
    vec_t r;
    r.i     = '{default: 0};
    r.i.rst = ctl[4];
    r.i.ifr = ctl[3];
    r.i.dmr = ctl[2];
    r.i.mg  = ctl[1];
    r.i.mrv = ctl[0];
    r.i.ia  = ia;
    r.i.da  = da;
    r.i.mrd = mrd;
    r.e     = e;
    r.ma    = ma;
    return r;
  endfunction

  task automatic do_reset();
    in_t z;
    z = '{default: 0};
    z.rst = 1'b1;
    @(posedge clk); #1; apply(z);
    @(posedge clk); #1; z.rst = 1'b0; apply(z);
  endtask

  task automatic model_check(input in_t x);
    logic bsy, mreq, ig, dg, irv, drv;
    logic [31:0] rd;
    bsy = 1'b0; mreq = 1'b0; ig = 1'b0; dg = 1'b0; irv = 1'b0; drv = 1'b0; rd = 32'h0;
    if (!x.rst) begin
      rd = x.mrd;
      if (txq.size() != 0) begin
        bsy  = 1'b1;
        mreq = !txq[0].granted;
        ig   = mreq && x.mg && !txq[0].owner;
        dg   = mreq && x.mg && txq[0].owner;
        irv  = txq[0].granted && x.mrv && !txq[0].owner;
        drv  = txq[0].granted && x.mrv && txq[0].owner;
      end
    end
    chk("rnd.busy", busy, bsy);
    chk("rnd.mem_req", bus.mem_req, mreq);
    chk("rnd.if_gnt", bus.if_gnt, ig);
    chk("rnd.dm_gnt", bus.dm_gnt, dg);
    chk("rnd.if_rvalid", bus.if_rvalid, irv);
    chk("rnd.dm_rvalid", bus.dm_rvalid, drv);
    chk("rnd.if_rdata", bus.if_rdata, rd);
    chk("rnd.dm_rdata", bus.dm_rdata, rd);
    if (mreq) begin
      chk("rnd.mem_addr", bus.mem_addr, txq[0].addr);
      chk("rnd.mem_we", bus.mem_we, txq[0].we);
      chk("rnd.mem_wstrb", bus.mem_wstrb, txq[0].wstrb);
      if (txq[0].we) chk("rnd.mem_wdata", bus.mem_wdata, txq[0].wdata);
    end
  endtask

  task automatic model_advance(input in_t x);
    tx_t t;
    logic dmw;
    if (x.rst) begin
      txq.delete();
      m_starve = 0;
    end else if (txq.size() == 0) begin
      if (x.ifr || x.dmr) begin
        dmw = x.dmr && (!x.ifr || (m_starve < LIM));
        if (dmw && x.ifr) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
        else if (!dmw) m_starve = 0;
        t.owner   = dmw;
        t.addr    = dmw ? x.da : x.ia;
        t.we      = dmw && x.dwe;
        t.wstrb   = dmw ? x.dws : 4'h0;
        t.wdata   = x.dwd;
        t.granted = 1'b0;
        txq.push_back(t);
      end
    end else if (!txq[0].granted) begin
      if (x.mg) begin
        t = txq[0];
        t.granted = 1'b1;
        txq[0] = t;
      end
    end else if (x.mrv) begin
      void'(txq.pop_front());
    end
  endtask

  initial begin
    int ng;
    int c;
    v = '{default: 0};
    v.rst = 1'b1;
    apply(v);

    vt.push_back(row(5'b10000, 32'h0,   32'h0,   32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b11111, 32'h100, 32'h0,   32'h13, 6'b000000, 32'h0));
    vt.push_back(row(5'b01010, 32'h100, 32'h0,   32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b01010, 32'h100, 32'h0,   32'h0,  6'b100011, 32'h100));
    vt.push_back(row(5'b00011, 32'h0,   32'h0,   32'h13, 6'b010001, 32'h0));
    vt.push_back(row(5'b00010, 32'h0,   32'h0,   32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b00001, 32'h0,   32'h0,   32'h55, 6'b000000, 32'h0));
    vt.push_back(row(5'b01010, 32'h200, 32'h0,   32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b01010, 32'h200, 32'h0,   32'h0,  6'b100011, 32'h200));
    vt.push_back(row(5'b10000, 32'h0,   32'h0,   32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b00001, 32'h0,   32'h0,   32'h77, 6'b000000, 32'h0));
    vt.push_back(row(5'b00110, 32'h0,   32'h300, 32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b00110, 32'h0,   32'h300, 32'h0,  6'b001011, 32'h300));
    vt.push_back(row(5'b00011, 32'h0,   32'h0,   32'hAB, 6'b000101, 32'h0));
    vt.push_back(row(5'b00000, 32'h0,   32'h0,   32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b01000, 32'h400, 32'h0,   32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b01001, 32'h400, 32'h0,   32'h5,  6'b000011, 32'h400));
    vt.push_back(row(5'b01010, 32'h400, 32'h0,   32'h0,  6'b100011, 32'h400));
    vt.push_back(row(5'b00001, 32'h0,   32'h0,   32'h5,  6'b010001, 32'h0));
    vt.push_back(row(5'b00000, 32'h0,   32'h0,   32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b01100, 32'h500, 32'h600, 32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b01110, 32'h500, 32'h600, 32'h0,  6'b001011, 32'h600));
    vt.push_back(row(5'b01001, 32'h500, 32'h0,   32'h66, 6'b000101, 32'h0));
    vt.push_back(row(5'b01010, 32'h500, 32'h0,   32'h0,  6'b000000, 32'h0));
    vt.push_back(row(5'b01010, 32'h500, 32'h0,   32'h0,  6'b100011, 32'h500));
    vt.push_back(row(5'b00001, 32'h0,   32'h0,   32'h99, 6'b010001, 32'h0));
    vt.push_back(row(5'b00000, 32'h0,   32'h0,   32'h0,  6'b000000, 32'h0));

    foreach (vt[k]) begin
      @(posedge clk); #1; apply(vt[k].i);
      @(negedge clk);
      chk($sformatf("vec%0d.if_gnt", k),    bus.if_gnt,    vt[k].e[5]);
      chk($sformatf("vec%0d.if_rvalid", k), bus.if_rvalid, vt[k].e[4]);
      chk($sformatf("vec%0d.dm_gnt", k),    bus.dm_gnt,    vt[k].e[3]);
      chk($sformatf("vec%0d.dm_rvalid", k), bus.dm_rvalid, vt[k].e[2]);
      chk($sformatf("vec%0d.mem_req", k),   bus.mem_req,   vt[k].e[1]);
      chk($sformatf("vec%0d.busy", k),      busy,          vt[k].e[0]);
      if (vt[k].e[1]) chk($sformatf("vec%0d.mem_addr", k), bus.mem_addr, vt[k].ma);
      if (vt[k].e[4]) chk($sformatf("vec%0d.if_rdata", k), bus.if_rdata, vt[k].i.mrd);
      if (vt[k].e[2]) chk($sformatf("vec%0d.dm_rdata", k), bus.dm_rdata, vt[k].i.mrd);
    end

    // Data write with three memory wait states
    v = '{default: 0};
    v.dmr = 1'b1; v.dwe = 1'b1; v.da = 32'h2000; v.dwd = 32'hDEADBEEF; v.dws = 4'hF;
    @(posedge clk); #1; apply(v);
    @(negedge clk); chk("wr.idle_busy", busy, 1'b0);
    for (int w = 0; w < 4; w++) begin
      v.mg = (w == 3);
      @(posedge clk); #1; apply(v);
      @(negedge clk);
      chk($sformatf("wr%0d.mem_req", w),   bus.mem_req,   1'b1);
      chk($sformatf("wr%0d.mem_we", w),    bus.mem_we,    1'b1);
      chk($sformatf("wr%0d.mem_addr", w),  bus.mem_addr,  32'h2000);
      chk($sformatf("wr%0d.mem_wdata", w), bus.mem_wdata, 32'hDEADBEEF);
      chk($sformatf("wr%0d.mem_wstrb", w), bus.mem_wstrb, 4'hF);
      chk($sformatf("wr%0d.dm_gnt", w),    bus.dm_gnt,    (w == 3));
      chk($sformatf("wr%0d.if_gnt", w),    bus.if_gnt,    1'b0);
    end
    v = '{default: 0};
    v.mrv = 1'b1; v.mrd = 32'hCAFE;
    @(posedge clk); #1; apply(v);
    @(negedge clk);
    chk("wr.dm_rvalid", bus.dm_rvalid, 1'b1);
    chk("wr.if_rvalid", bus.if_rvalid, 1'b0);
    chk("wr.mem_req",   bus.mem_req,   1'b0);
    v.mrv = 1'b0;
    @(posedge clk); #1; apply(v);
    @(negedge clk); chk("wr.done_busy", busy, 1'b0);

    // Continuous contention: dm,dm,dm,dm,if repeating
    do_reset();
    v = '{default: 0};
    v.ifr = 1'b1; v.dmr = 1'b1; v.mg = 1'b1; v.mrv = 1'b1; v.ia = 32'h10; v.da = 32'h20;
    apply(v);
    ng = 0;
    for (c = 0; c < 60 && ng < 15; c++) begin
      @(negedge clk);
      if (bus.if_gnt || bus.dm_gnt) begin
        chk("ord.onehot", bus.if_gnt & bus.dm_gnt, 1'b0);
        chk($sformatf("ord.g%0d_is_if", ng), bus.if_gnt, (ng % 5 == 4));
        ng++;
      end
      @(posedge clk); #1;
    end
    chk("ord.count", ng, 15);

    // Stray rvalid in IDLE must not disturb the starvation count: dm,dm | idle | dm,dm,if
    do_reset();
    apply(v);
    ng = 0;
    c  = 0;
    while (ng < 2 && c < 40) begin
      @(negedge clk);
      if (bus.dm_gnt) ng++;
      @(posedge clk); #1;
      c++;
    end
    chk("stray.pre_count", ng, 2);
    v.ifr = 1'b0; v.dmr = 1'b0; apply(v);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stray.busy",      busy,          1'b0);
    chk("stray.if_rvalid", bus.if_rvalid, 1'b0);
    chk("stray.dm_rvalid", bus.dm_rvalid, 1'b0);
    @(posedge clk); #1;
    v.ifr = 1'b1; v.dmr = 1'b1; apply(v);
    ng = 0;
    for (c = 0; c < 30 && ng < 3; c++) begin
      @(negedge clk);
      if (bus.if_gnt || bus.dm_gnt) begin
        chk($sformatf("stray.g%0d_is_if", ng), bus.if_gnt, (ng == 2));
        ng++;
      end
      @(posedge clk); #1;
    end
    chk("stray.count", ng, 3);

    // Randomized traffic against the transaction-queue model
    do_reset();
    v = '{default: 0};
    txq.delete();
    m_starve = 0;
    seen_ig  = 1'b0;
    seen_dg  = 1'b0;
    for (int r = 0; r < 3000; r++) begin
      if (seen_ig) v.ifr = 1'b0;
      if (seen_dg) v.dmr = 1'b0;
      if (txq.size() != 0 && !txq[0].granted && $urandom_range(0, 3) == 0) begin
        if (!txq[0].owner) v.ifr = 1'b0;
        else v.dmr = 1'b0;
      end
      if (!v.ifr && $urandom_range(0, 2) == 0) begin
        v.ifr = 1'b1;
        v.ia  = $urandom;
      end
      if (!v.dmr && $urandom_range(0, 2) == 0) begin
        v.dmr = 1'b1;
        v.da  = $urandom;
        v.dwe = 1'($urandom_range(0, 1));
        v.dws = 4'($urandom_range(0, 15));
        v.dwd = $urandom;
      end
      v.mg  = ($urandom_range(0, 2) != 0);
      v.mrv = 1'($urandom_range(0, 1));
      v.mrd = $urandom;
      v.rst = ($urandom_range(0, 63) == 0);
      apply(v);
      @(negedge clk);
      model_check(v);
      seen_ig = bus.if_gnt;
      seen_dg = bus.dm_gnt;
      model_advance(v);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
